// File: rtl/sa_fifo_ctrl_80x18.sv
`timescale 1ns/1ps
// Valid/ready FIFO controller for the 80x18 two-port RAM. The RAM read path
// is two stages deep (address register, then output register).
//
// stage | meaning
// S1    | read address captured in RAM (re issued), data not yet in dout
// S2    | data held in RAM output register (ore issued), presented on rd_pd
module sa_fifo_ctrl_80x18 #(
  parameter int DEPTH = 80,
  parameter int AW    = 7,
  parameter int DW    = 18
) (
  input  logic          clk,
  input  logic          reset_,
  input  logic          wr_pvld,
  output logic          wr_prdy,
  input  logic [DW-1:0] wr_pd,
  output logic          rd_pvld,
  input  logic          rd_prdy,
  output logic [DW-1:0] rd_pd,
  output logic          ram_we,
  output logic [AW-1:0] ram_wa,
  output logic [DW-1:0] ram_di,
  output logic          ram_re,
  output logic [AW-1:0] ram_ra,
  output logic          ram_ore,
  output logic          ram_byp_sel,
  output logic [DW-1:0] ram_dbyp,
  input  logic [DW-1:0] ram_dout,
  output logic [AW-1:0] fifo_count
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] FULL = AW'(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] count;
  logic          s1_vld;
  logic          s2_vld;
  logic          rdy_en;

  logic          wr_acc;
  logic          pop;
  logic          s2_adv;
  logic          s1_load;
  logic [AW-1:0] unfetched;

  // rdy_en keeps wr_prdy low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) rdy_en <= 1'b0;
    else         rdy_en <= 1'b1;
  end

  always_comb begin
    wr_prdy   = rdy_en & (count < FULL);
    wr_acc    = wr_pvld & wr_prdy;
    pop       = s2_vld & rd_prdy;
    unfetched = count - {{(AW-1){1'b0}}, s1_vld} - {{(AW-1){1'b0}}, s2_vld};
    s2_adv    = s1_vld & (~s2_vld | rd_prdy);
    s1_load   = (unfetched != '0) & (~s1_vld | s2_adv);
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
    end else begin
      if (wr_acc)  wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
      if (s1_load) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      s1_vld <= s1_load | (s1_vld & ~s2_adv);
      s2_vld <= s2_adv | (s2_vld & ~rd_prdy);
    end
  end

  // Stalled stages simply withhold re/ore so the RAM registers hold their contents.
  always_comb begin
    ram_we      = wr_acc;
    ram_wa      = wr_ptr;
    ram_di      = wr_pd;
    ram_re      = s1_load;
    ram_ra      = rd_ptr;
    ram_ore     = s2_adv;
    ram_byp_sel = 1'b0;
    ram_dbyp    = '0;
    rd_pvld     = s2_vld;
    rd_pd       = ram_dout;
    fifo_count  = count;
  end

endmodule

// File: doc/sa_fifo_ctrl_80x18.md
Name: sa_fifo_ctrl_80x18

Overview:
- Flow-control stage wrapped around the 80x18 two-port RAM with registered read address and registered output (re -> ore, two-cycle read).
- Converts a valid/ready write stream and a valid/ready read stream into RAM ram_we/ram_wa/ram_re/ram_ra/ram_ore strobes.
- Tracks occupancy and handles the two-stage read pipeline under backpressure.
- Sits directly upstream of the RAM and supplies every RAM control/data input; ram_dout is the read data returned.

Parameters:
- DEPTH, 80, number of RAM entries; addresses 0..DEPTH-1.
- AW, 7, address width; must satisfy 2^AW >= DEPTH.
- DW, 18, data width.

Ports:
- clk  in  1  clock.
- reset_  in  1  asynchronous reset, active-low.
- wr_pvld  in  1  write data valid.
- wr_prdy  out  1  write ready; high when occupancy < DEPTH.
- wr_pd  in  DW  write payload.
- rd_pvld  out  1  read data valid.
- rd_prdy  in  1  read ready.
- rd_pd  out  DW  read payload; wired to ram_dout.
- ram_we  out  1  RAM write enable.
- ram_wa  out  AW  RAM write address.
- ram_di  out  DW  RAM write data; wired to wr_pd.
- ram_re  out  1  RAM read-address capture enable.
- ram_ra  out  AW  RAM read address.
- ram_ore  out  1  RAM output-register enable.
- ram_byp_sel  out  1  tied 0.
- ram_dbyp  out  DW  tied 0.
- ram_dout  in  DW  RAM registered output.
- fifo_count  out  AW  entries written and not yet popped (0..DEPTH).

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, rd_ptr=0, count=0, s1_vld=0, s2_vld=0.
  - Output values during reset: wr_prdy=0; rd_pvld=0; fifo_count=0; ram_we=ram_re=ram_ore=0.
  - wr_prdy goes high the first cycle after reset_ deasserts.
- Write path:
  - wr_acc = wr_pvld & wr_prdy.
  - ram_we = wr_acc, ram_wa = wr_ptr, both combinational.
  - wr_ptr increments on wr_acc; wraps DEPTH-1 -> 0.
- Read pipeline:
  - S1 = address captured in RAM (re done). S2 = data in RAM output register (ore done).
  - unfetched = count - s1_vld - s2_vld.
  - s2_adv = s1_vld & (~s2_vld | rd_prdy).
  - s1_load = (unfetched > 0) & (~s1_vld | s2_adv).
  - ram_re = s1_load, ram_ra = rd_ptr. rd_ptr increments on s1_load; wraps DEPTH-1 -> 0.
  - ram_ore = s2_adv.
  - s1_vld next = s1_load | (s1_vld & ~s2_adv).
  - s2_vld next = s2_adv | (s2_vld & ~rd_prdy).
  - rd_pvld = s2_vld; rd_pd = ram_dout.
- Stall hold:
  - When S2 is stalled, ore stays low and RAM dout holds.
  - When S1 is stalled, re stays low and the captured address holds.
  - No data is lost and no skid buffer is needed.
- Entry retirement: an entry is freed only on pop (rd_pvld & rd_prdy). Addresses held in S1/S2 are therefore never overwritten.
- Occupancy: count += wr_acc, -= pop; simultaneous push and pop leaves count unchanged. fifo_count = count.
- Full (count==DEPTH): wr_prdy=0. A pop in the same cycle does not raise wr_prdy until the next cycle, since wr_prdy is combinational on the registered count.
- Empty: no re/ore is issued; rd_pvld=0.
- Latency: write accepted at edge T -> re at edge T+1 -> ore at edge T+2 -> rd_pvld high after T+2, i.e. 3 cycles fall-through.
- Throughput: one push and one pop per cycle sustained.
- Reset mid-operation: all state cleared immediately; in-flight reads are discarded; RAM contents are don't-care.

Test Plan:
- Single push 0x2ABCD at cycle 0, rd_prdy=1 -> ram_re cycle 1 (ra=0), ram_ore cycle 2, rd_pvld with rd_pd=0x2ABCD visible after cycle 2; fifo_count returns 0 after pop.
- Fill 80 entries (data = index) with rd_prdy=0 -> wr_prdy=0 at count=80; rd_pvld=1 with data 0; exactly 2 re and 1 ore issued.
- From full, hold rd_prdy=1 with wr_pvld=1 -> one pop then one push per cycle; data order 0..79 then new data; no lost or duplicated words.
- Pointer wrap: push/pop 200 words with random rd_prdy (50%) and wr_pvld (70%) -> scoreboard in-order match; ram_wa/ram_ra wrap 79 -> 0, never reach 80.
- rd_prdy toggling 1,0,0,1 with S1 and S2 full -> ram_ore and ram_re low during stall; rd_pd stable; no re while S1 is held.
- Assert reset_=0 with 5 entries in flight -> rd_pvld=0, fifo_count=0 immediately; after release, the next push reads back correctly from address 0.
